// File: rtl/fx2_pkg.sv
// Shared constants for the FX2LP slave-FIFO model: endpoint addresses, bus width, error bits.
package fx2_pkg;
  localparam logic [1:0] EP2_ADR = 2'b00;
  localparam logic [1:0] EP4_ADR = 2'b01;
  localparam logic [1:0] EP6_ADR = 2'b10;
  localparam logic [1:0] EP8_ADR = 2'b11;

  localparam int FD_WIDTH = 16;

  localparam int ERR_UNDERFLOW = 0;
  localparam int ERR_OVERFLOW  = 1;
  localparam int ERR_PROTOCOL  = 2;
endpackage

// File: rtl/fx2_slave_fifo_model_if.sv
// Strobe, flag and host-side signals between an FPGA master and the FX2 slave-FIFO model.
interface fx2_slave_fifo_model_if #(
  parameter int DEPTH_LOG2 = 5
);
  import fx2_pkg::*;

  logic                  SLRD;
  logic                  SLWR;
  logic                  SLOE;
  logic [1:0]            FIFOADR;
  logic                  FLAGA;
  logic                  FLAGD;
  logic                  host_wr_en;
  logic [FD_WIDTH-1:0]   host_wr_data;
  logic                  host_wr_full;
  logic                  host_rd_en;
  logic [FD_WIDTH-1:0]   host_rd_data;
  logic                  host_rd_valid;
  logic [DEPTH_LOG2:0]   ep6_count;
  logic                  err_clr;
  logic [2:0]            err;

  modport slave (
    input  SLRD, SLWR, SLOE, FIFOADR, host_wr_en, host_wr_data, host_rd_en, err_clr,
    output FLAGA, FLAGD, host_wr_full, host_rd_data, host_rd_valid, ep6_count, err
  );

  modport master (
    output SLRD, SLWR, SLOE, FIFOADR, host_wr_en, host_wr_data, host_rd_en, err_clr,
    input  FLAGA, FLAGD, host_wr_full, host_rd_data, host_rd_valid, ep6_count, err
  );
endinterface

// File: rtl/fx2_ep_fifo.sv
// First-word-fall-through endpoint buffer; head is combinational from the read pointer.
// A pop frees the slot a same-edge push needs, so push+pop on a full buffer both succeed.
module fx2_ep_fifo #(
  parameter int DEPTH_LOG2 = 5,
  parameter int WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_dat,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end
endmodule

// File: rtl/fx2_slave_fifo_model.sv
// FX2LP slave-FIFO model: EP2 OUT (host->master) and EP6 IN (master->host) buffers,
// strobe decode, FD tristate, flags, host pop register and sticky error reporting.
module fx2_slave_fifo_model
  import fx2_pkg::*;
#(
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                 CLKOUT,
  input  logic                 rst_n,
  inout  wire [FD_WIDTH-1:0]   FD,
  fx2_slave_fifo_model_if.slave bus
);
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [FD_WIDTH-1:0]   ep2_head;
  logic [DEPTH_LOG2:0]   ep2_count;
  logic                  ep2_full;
  logic                  ep2_empty;
  logic [FD_WIDTH-1:0]   ep6_head;
  logic [DEPTH_LOG2:0]   ep6_count;
  logic                  ep6_full;
  logic                  ep6_empty;
  logic                  ep2_pop_req;
  logic                  ep6_push_req;
  logic                  bad_adr;
  logic                  fd_oe;
  logic [2:0]            err_ev;
  logic [2:0]            err_q;
  logic [FD_WIDTH-1:0]   rd_data_q;
  logic                  rd_valid_q;

  assign ep2_pop_req  = !bus.SLRD && (bus.FIFOADR == EP2_ADR);
  assign ep6_push_req = !bus.SLWR && (bus.FIFOADR == EP6_ADR);
  assign bad_adr      = (bus.FIFOADR == EP4_ADR) || (bus.FIFOADR == EP8_ADR);

  fx2_ep_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(FD_WIDTH)) u_ep2 (
    .clk      (CLKOUT),
    .rst_n    (rst_n),
    .push     (bus.host_wr_en),
    .push_dat (bus.host_wr_data),
    .pop      (ep2_pop_req),
    .head     (ep2_head),
    .count    (ep2_count),
    .full     (ep2_full),
    .empty    (ep2_empty)
  );

  fx2_ep_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(FD_WIDTH)) u_ep6 (
    .clk      (CLKOUT),
    .rst_n    (rst_n),
    .push     (ep6_push_req),
    .push_dat (FD),
    .pop      (bus.host_rd_en),
    .head     (ep6_head),
    .count    (ep6_count),
    .full     (ep6_full),
    .empty    (ep6_empty)
  );

  // rst_n in the enable lets the bus release the instant reset asserts.
  assign fd_oe = rst_n && !bus.SLOE && (bus.FIFOADR == EP2_ADR);
  assign FD    = fd_oe ? (ep2_empty ? '0 : ep2_head) : 'z;

  assign bus.FLAGA        = (ep2_count != '0);
  assign bus.FLAGD        = (ep6_count != FULL_CNT);
  assign bus.host_wr_full = ep2_full;
  assign bus.ep6_count    = ep6_count;
  assign bus.host_rd_data = rd_data_q;
  assign bus.host_rd_valid = rd_valid_q;
  assign bus.err          = err_q;

  always_comb begin
    err_ev                = '0;
    err_ev[ERR_UNDERFLOW] = ep2_pop_req && ep2_empty;
    err_ev[ERR_OVERFLOW]  = ep6_push_req && ep6_full && !bus.host_rd_en;
    err_ev[ERR_PROTOCOL]  = ((!bus.SLRD || !bus.SLWR) && bad_adr)
                          || (!bus.SLRD && (bus.FIFOADR == EP6_ADR))
                          || (!bus.SLWR && (bus.FIFOADR == EP2_ADR))
                          || (!bus.SLOE && !bus.SLWR);
  end

  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      err_q <= (bus.err_clr ? 3'b000 : err_q) | err_ev;
      if (bus.host_rd_en && !ep6_empty) begin
        rd_data_q  <= ep6_head;
        rd_valid_q <= 1'b1;
      end else begin
        rd_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fx2_slave_fifo_model.sv
// Directed bench for the FX2 slave-FIFO model; FD has pull-ups so a released bus reads FFFF.
module tb_fx2_slave_fifo_model;
  localparam int DL2 = 5;

  logic        clk;
  logic        rst_n;
  logic        tb_fd_oe;
  logic [15:0] tb_fd_dat;
  wire  [15:0] fd;
  int          checks;
  int          errors;

  fx2_slave_fifo_model_if #(.DEPTH_LOG2(DL2)) bus ();

  assign fd = tb_fd_oe ? tb_fd_dat : 16'hzzzz;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pu
      pullup (fd[gi]);
    end
  endgenerate

  fx2_slave_fifo_model #(.DEPTH_LOG2(DL2)) dut (
    .CLKOUT (clk),
    .rst_n  (rst_n),
    .FD     (fd),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.SLRD = 1'b1; bus.SLWR = 1'b1; bus.SLOE = 1'b1; bus.FIFOADR = 2'b00;
    bus.host_wr_en = 1'b0; bus.host_rd_en = 1'b0; bus.err_clr = 1'b0;
    tb_fd_oe = 1'b0;
  endtask

  task automatic clear_err();
    bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    bus.host_wr_data = 16'h0; tb_fd_dat = 16'h0;
    rst_n = 1'b0;
    #12;
    checks++; if (bus.FLAGA !== 1'b0) begin errors++; $display("FAIL reset_flaga got %b want 0", bus.FLAGA); end
    checks++; if (bus.FLAGD !== 1'b1) begin errors++; $display("FAIL reset_flagd got %b want 1", bus.FLAGD); end
    checks++; if (bus.host_wr_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.host_wr_full); end
    checks++; if (bus.host_rd_valid !== 1'b0 || bus.host_rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd got %b/%h want 0/0000", bus.host_rd_valid, bus.host_rd_data); end
    checks++; if (bus.ep6_count !== 6'd0 || bus.err !== 3'b000) begin errors++; $display("FAIL reset_cnt_err got %0d/%b want 0/000", bus.ep6_count, bus.err); end
    checks++; if (fd !== 16'hFFFF) begin errors++; $display("FAIL reset_fd got %h want FFFF", fd); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ep2_drain();
    for (int i = 1; i <= 18; i++) begin
      bus.host_wr_en = 1'b1; bus.host_wr_data = 16'(i);
      tick();
    end
    bus.host_wr_en = 1'b0;
    checks++; if (bus.FLAGA !== 1'b1) begin errors++; $display("FAIL drain_flaga_full got %b want 1", bus.FLAGA); end
    bus.SLOE = 1'b0; bus.FIFOADR = 2'b00; bus.SLRD = 1'b0;
    #1;
    for (int i = 1; i <= 18; i++) begin
      checks++; if (fd !== 16'(i) || bus.FLAGA !== 1'b1) begin errors++; $display("FAIL drain_word%0d got %h/%b want %h/1", i, fd, bus.FLAGA, 16'(i)); end
      tick();
    end
    bus.SLRD = 1'b1;
    #1;
    checks++; if (bus.FLAGA !== 1'b0) begin errors++; $display("FAIL drain_flaga_empty got %b want 0", bus.FLAGA); end
    checks++; if (fd !== 16'h0000) begin errors++; $display("FAIL drain_fd_empty got %h want 0000", fd); end
    checks++; if (bus.err !== 3'b000) begin errors++; $display("FAIL drain_err got %b want 000", bus.err); end
    idle();
  endtask

  task automatic test_ep6_overflow();
    bus.FIFOADR = 2'b10; bus.SLWR = 1'b0; tb_fd_oe = 1'b1;
    for (int i = 0; i < 33; i++) begin
      tb_fd_dat = 16'hA000 + 16'(i);
      tick();
      if (i == 30) begin
        checks++; if (bus.FLAGD !== 1'b1 || bus.ep6_count !== 6'd31) begin errors++; $display("FAIL ep6_31 got %b/%0d want 1/31", bus.FLAGD, bus.ep6_count); end
      end
      if (i == 31) begin
        checks++; if (bus.FLAGD !== 1'b0 || bus.ep6_count !== 6'd32 || bus.err !== 3'b000) begin errors++; $display("FAIL ep6_32 got %b/%0d/%b want 0/32/000", bus.FLAGD, bus.ep6_count, bus.err); end
      end
    end
    idle();
    checks++; if (bus.err !== 3'b010 || bus.ep6_count !== 6'd32) begin errors++; $display("FAIL ep6_ovf got %b/%0d want 010/32", bus.err, bus.ep6_count); end
    clear_err();
    checks++; if (bus.err !== 3'b000) begin errors++; $display("FAIL ep6_clr got %b want 000", bus.err); end
    bus.host_rd_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      checks++; if (bus.host_rd_valid !== 1'b1 || bus.host_rd_data !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL ep6_pop%0d got %b/%h want 1/%h", i, bus.host_rd_valid, bus.host_rd_data, 16'hA000 + 16'(i)); end
    end
    tick();
    checks++; if (bus.host_rd_valid !== 1'b0 || bus.host_rd_data !== 16'hA01F) begin errors++; $display("FAIL ep6_pop_empty got %b/%h want 0/A01F", bus.host_rd_valid, bus.host_rd_data); end
    checks++; if (bus.ep6_count !== 6'd0 || bus.FLAGD !== 1'b1) begin errors++; $display("FAIL ep6_drained got %0d/%b want 0/1", bus.ep6_count, bus.FLAGD); end
    idle();
  endtask

  task automatic test_underflow();
    bus.FIFOADR = 2'b00; bus.SLRD = 1'b0;
    tick();
    bus.SLRD = 1'b1;
    checks++; if (bus.err !== 3'b001 || bus.FLAGA !== 1'b0) begin errors++; $display("FAIL udf got %b/%b want 001/0", bus.err, bus.FLAGA); end
    clear_err();
    checks++; if (bus.err !== 3'b000) begin errors++; $display("FAIL udf_clr got %b want 000", bus.err); end
    bus.SLRD = 1'b0; bus.err_clr = 1'b1;
    tick();
    idle();
    checks++; if (bus.err !== 3'b001) begin errors++; $display("FAIL udf_clr_same got %b want 001", bus.err); end
    clear_err();
  endtask

  task automatic test_simultaneous();
    bus.host_wr_en = 1'b1; bus.host_wr_data = 16'h1111;
    tick();
    bus.host_wr_data = 16'h2222; bus.SLRD = 1'b0; bus.SLOE = 1'b0;
    tick();
    bus.host_wr_en = 1'b0; bus.SLRD = 1'b1;
    #1;
    checks++; if (fd !== 16'h2222 || bus.FLAGA !== 1'b1 || bus.err !== 3'b000) begin errors++; $display("FAIL sim_ep2 got %h/%b/%b want 2222/1/000", fd, bus.FLAGA, bus.err); end
    bus.SLRD = 1'b0;
    tick();
    bus.SLRD = 1'b1;
    checks++; if (bus.FLAGA !== 1'b0) begin errors++; $display("FAIL sim_ep2_cnt1 got %b want 0", bus.FLAGA); end
    bus.host_wr_en = 1'b1; bus.host_wr_data = 16'h3333; bus.SLRD = 1'b0;
    tick();
    bus.host_wr_en = 1'b0; bus.SLRD = 1'b1;
    #1;
    checks++; if (fd !== 16'h3333 || bus.FLAGA !== 1'b1 || bus.err !== 3'b001) begin errors++; $display("FAIL sim_ep2_empty got %h/%b/%b want 3333/1/001", fd, bus.FLAGA, bus.err); end
    bus.SLRD = 1'b0;
    tick();
    idle();
    clear_err();
    bus.FIFOADR = 2'b10; bus.SLWR = 1'b0; tb_fd_oe = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tb_fd_dat = 16'hB000 + 16'(i);
      tick();
    end
    tb_fd_dat = 16'hB0FF; bus.host_rd_en = 1'b1;
    tick();
    bus.SLWR = 1'b1; tb_fd_oe = 1'b0;
    checks++; if (bus.host_rd_valid !== 1'b1 || bus.host_rd_data !== 16'hB000) begin errors++; $display("FAIL sim_ep6_pop got %b/%h want 1/B000", bus.host_rd_valid, bus.host_rd_data); end
    checks++; if (bus.FLAGD !== 1'b0 || bus.ep6_count !== 6'd32 || bus.err !== 3'b000) begin errors++; $display("FAIL sim_ep6_full got %b/%0d/%b want 0/32/000", bus.FLAGD, bus.ep6_count, bus.err); end
    for (int i = 1; i <= 32; i++) begin
      tick();
      checks++; if (bus.host_rd_data !== ((i == 32) ? 16'hB0FF : 16'hB000 + 16'(i))) begin errors++; $display("FAIL sim_ep6_drain%0d got %h want %h", i, bus.host_rd_data, (i == 32) ? 16'hB0FF : 16'hB000 + 16'(i)); end
    end
    idle();
    tick();
  endtask

  task automatic test_protocol();
    bus.FIFOADR = 2'b01; bus.SLWR = 1'b0; tb_fd_oe = 1'b1; tb_fd_dat = 16'h5555;
    tick();
    idle();
    checks++; if (bus.err !== 3'b100 || bus.ep6_count !== 6'd0) begin errors++; $display("FAIL proto_ep4 got %b/%0d want 100/0", bus.err, bus.ep6_count); end
    clear_err();
    bus.SLOE = 1'b0; bus.FIFOADR = 2'b10;
    #1;
    checks++; if (fd !== 16'hFFFF) begin errors++; $display("FAIL proto_fd_hiz got %h want FFFF", fd); end
    bus.SLWR = 1'b0; tb_fd_oe = 1'b1; tb_fd_dat = 16'h6666;
    tick();
    idle();
    checks++; if (bus.err !== 3'b100 || bus.ep6_count !== 6'd1) begin errors++; $display("FAIL proto_oe_wr got %b/%0d want 100/1", bus.err, bus.ep6_count); end
    clear_err();
    bus.host_rd_en = 1'b1;
    tick();
    bus.host_rd_en = 1'b0;
    checks++; if (bus.host_rd_data !== 16'h6666) begin errors++; $display("FAIL proto_oe_wr_data got %h want 6666", bus.host_rd_data); end
  endtask

  task automatic test_reset_mid();
    bus.host_wr_en = 1'b1; bus.host_wr_data = 16'h7001;
    tick();
    bus.host_wr_data = 16'h7002;
    tick();
    bus.host_wr_en = 1'b0;
    bus.FIFOADR = 2'b10; bus.SLWR = 1'b0; tb_fd_oe = 1'b1; tb_fd_dat = 16'h8001;
    tick();
    idle();
    bus.SLOE = 1'b0; bus.FIFOADR = 2'b00;
    #1;
    checks++; if (fd !== 16'h7001 || bus.ep6_count !== 6'd1) begin errors++; $display("FAIL mid_pre got %h/%0d want 7001/1", fd, bus.ep6_count); end
    rst_n = 1'b0;
    #1;
    checks++; if (fd !== 16'hFFFF) begin errors++; $display("FAIL mid_fd_release got %h want FFFF", fd); end
    checks++; if (bus.FLAGA !== 1'b0 || bus.FLAGD !== 1'b1 || bus.ep6_count !== 6'd0) begin errors++; $display("FAIL mid_flags got %b/%b/%0d want 0/1/0", bus.FLAGA, bus.FLAGD, bus.ep6_count); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (fd !== 16'h0000 || bus.FLAGA !== 1'b0) begin errors++; $display("FAIL mid_post got %h/%b want 0000/0", fd, bus.FLAGA); end
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ep2_drain();
    test_ep6_overflow();
    test_underflow();
    test_simultaneous();
    test_protocol();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
